// File: rtl/fetch_pkg.sv
// fetch_pkg
//  Shared types and constants for the RV32I fetch stage.
//  - fetch_state_t: fetch FSM states (IDLE, REQ, RESP, HOLD).
//  - NOP_INSTR_DEFAULT: bubble encoding, addi x0,x0,0.
//  - RESET_PC_DEFAULT: fetch address after reset.
//  - alignPc: clears the two low address bits of a redirect target.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//  Instruction-memory request/response bus between the fetch stage (master)
//  and instruction memory (slave).
//  Handshake: a request transfers on a cycle where ImemReq && ImemGnt are both
//  high; ImemAddr is meaningful whenever ImemReq is high. Exactly one response
//  (ImemRValid high for one cycle, ImemRData valid in that cycle) follows each
//  transferred request, in order, no earlier than the cycle after the grant.
//  Signals:
//    ImemReq     master->slave  request valid
//    ImemAddr    master->slave  32-bit word-aligned fetch address
//    ImemGnt     slave->master  request accepted this cycle
//    ImemRValid  slave->master  read data valid
//    ImemRData   slave->master  32-bit instruction word
interface fetch_stage_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt;
  logic        ImemRValid;
  logic [31:0] ImemRData;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemGnt,
    input  ImemRValid,
    input  ImemRData
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemGnt,
    output ImemRValid,
    output ImemRData
  );
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg
//  Pipeline register carrying instruction, PC and PC+4 plus a valid bit.
//  Update priority: flush > stall > load > bubble. Flush and bubble both
//  produce the NOP encoding with zeroed PCs and valid cleared.
//  Ports:
//    clk, rst_n             clock (rising edge), async active-low reset
//    stall                  hold every output
//    flush                  load a bubble (wins over stall and load)
//    load                   capture instrIn/pcIn/pcPlus4In as a valid entry
//    instrIn, pcIn, pcPlus4In  incoming entry
//    instrOut, pcOut, pcPlus4Out, validOut  registered entry
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] instrIn,
  input  logic [31:0] pcIn,
  input  logic [31:0] pcPlus4In,
  output logic [31:0] instrOut,
  output logic [31:0] pcOut,
  output logic [31:0] pcPlus4Out,
  output logic        validOut
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instrOut   <= NOP_INSTR;
      pcOut      <= 32'h0;
      pcPlus4Out <= 32'h0;
      validOut   <= 1'b0;
    end else if (flush) begin
      instrOut   <= NOP_INSTR;
      pcOut      <= 32'h0;
      pcPlus4Out <= 32'h0;
      validOut   <= 1'b0;
    end else if (stall) begin
      instrOut   <= instrOut;
      pcOut      <= pcOut;
      pcPlus4Out <= pcPlus4Out;
      validOut   <= validOut;
    end else if (load) begin
      instrOut   <= instrIn;
      pcOut      <= pcIn;
      pcPlus4Out <= pcPlus4In;
      validOut   <= 1'b1;
    end else begin
      instrOut   <= NOP_INSTR;
      pcOut      <= 32'h0;
      pcPlus4Out <= 32'h0;
      validOut   <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//  RV32I instruction fetch plus IF/ID register. Keeps a single request
//  outstanding to instruction memory, owns the fetch PC, applies EX
//  redirects and delivers InstrD/PCD/PCPlus4D to decode.
//  Ports:
//    clk, rst_n     clock (rising edge), async active-low reset
//    StallF         do not issue a new fetch request
//    StallD         hold the IF/ID register
//    FlushD         load a bubble into the IF/ID register
//    PCSrcE         redirect taken this cycle
//    PCTargetE      redirect target (low two bits ignored)
//    imem           instruction-memory bus, master side
//    InstrD, PCD, PCPlus4D, ValidD  IF/ID register outputs
//    StateDbg       current fetch FSM state
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 StallF,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 PCSrcE,
  input  logic [31:0]          PCTargetE,
  fetch_stage_if.master        imem,
  output logic [31:0]          InstrD,
  output logic [31:0]          PCD,
  output logic [31:0]          PCPlus4D,
  output logic                 ValidD,
  output fetch_state_t         StateDbg
);

  fetch_state_t state;
  logic [31:0]  pcF;
  logic [31:0]  pcPlus4F;
  logic [31:0]  pcTarget;
  logic [31:0]  skidInstr;
  logic         kill;
  logic         handOff;
  logic [31:0]  handInstr;

  assign pcPlus4F = pcF + 32'd4;
  assign pcTarget = alignPc(PCTargetE);
  assign StateDbg = state;

  // A redirect in REQ suppresses the request so the stale PC is never fetched.
  assign imem.ImemAddr = pcF;
  assign imem.ImemReq  = (state == REQ) && !StallF && !PCSrcE;

  // Hand-off to decode: either straight from memory or from the skid buffer.
  // A redirect in the same cycle always wins and drops the instruction.
  always_comb begin
    handOff   = 1'b0;
    handInstr = skidInstr;
    case (state)
      RESP: begin
        if (imem.ImemRValid && !kill && !PCSrcE && !StallD) begin
          handOff   = 1'b1;
          handInstr = imem.ImemRData;
        end
      end
      HOLD: begin
        if (!PCSrcE && !StallD) begin
          handOff = 1'b1;
        end
      end
      default: begin
        handOff   = 1'b0;
        handInstr = skidInstr;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pcF       <= RESET_PC;
      kill      <= 1'b0;
      skidInstr <= NOP_INSTR;
    end else begin
      // PCF only moves on a redirect or when its instruction leaves for decode.
      if (PCSrcE) begin
        pcF <= pcTarget;
      end else if (handOff) begin
        pcF <= pcPlus4F;
      end

      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem.ImemReq && imem.ImemGnt) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (imem.ImemRValid) begin
            kill <= 1'b0;
            if (kill || PCSrcE || !StallD) begin
              state <= REQ;
            end else begin
              skidInstr <= imem.ImemRData;
              state     <= HOLD;
            end
          end else if (PCSrcE) begin
            // Response still owed for the old PC; remember to drop it.
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (PCSrcE || !StallD) begin
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (StallD),
    .flush      (FlushD),
    .load       (handOff),
    .instrIn    (handInstr),
    .pcIn       (pcF),
    .pcPlus4In  (pcPlus4F),
    .instrOut   (InstrD),
    .pcOut      (PCD),
    .pcPlus4Out (PCPlus4D),
    .validOut   (ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

  logic         clk;
  logic         rst_n;
  logic         StallF;
  logic         StallD;
  logic         FlushD;
  logic         PCSrcE;
  logic [31:0]  PCTargetE;
  logic [31:0]  InstrD;
  logic [31:0]  PCD;
  logic [31:0]  PCPlus4D;
  logic         ValidD;
  fetch_state_t StateDbg;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (imem),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .StateDbg  (StateDbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Memory model state: data returned is address ^ dataXor.
  logic        rvPending;
  logic [31:0] rvAddr;
  int          rvWait;
  int          memLat;
  logic [31:0] dataXor;

  // Scoreboard: expected instruction stream into decode.
  logic [31:0] expQ[$];

  task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock cycle: capture handshakes before the edge, update the memory
  // model after it, and score any new instruction delivered to decode.
  task automatic tick();
    logic        gntFire;
    logic        rvFire;
    logic        stallNow;
    logic [31:0] gntAddr;
    #1;
    gntFire  = imem.ImemReq && imem.ImemGnt;
    gntAddr  = imem.ImemAddr;
    rvFire   = imem.ImemRValid;
    stallNow = StallD;
    @(posedge clk);
    @(negedge clk);
    if (rvFire) rvPending = 1'b0;
    else if (rvPending && rvWait > 0) rvWait--;
    if (gntFire) begin
      rvPending = 1'b1;
      rvAddr    = gntAddr;
      rvWait    = memLat;
    end
    imem.ImemRValid = rvPending && (rvWait == 0);
    imem.ImemRData  = rvAddr ^ dataXor;
    if (ValidD && !stallNow) begin
      if (expQ.size() == 0) checkEq("sbUnexpected", {31'b0, ValidD}, 32'd0);
      else checkEq("sbInstr", InstrD, expQ.pop_front());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 1'b0; PCTargetE = 32'h0;
    imem.ImemGnt = 1'b1; imem.ImemRValid = 1'b0; imem.ImemRData = 32'h0;
    rvPending = 1'b0; rvAddr = 32'h0; rvWait = 0; memLat = 0; dataXor = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    checkEq("rstInstrD", InstrD, NOP);
    checkEq("rstValidD", {31'b0, ValidD}, 32'd0);
    checkEq("rstPCD", PCD, 32'h0);
    checkEq("rstPCPlus4D", PCPlus4D, 32'h0);
    checkEq("rstReq", {31'b0, imem.ImemReq}, 32'd0);
    checkEq("rstState", 32'(StateDbg), 32'(IDLE));
    checkEq("rstAddr", imem.ImemAddr, 32'h0);
    rst_n = 1'b1;

    // 1: zero-wait memory returning PC as data
    tick();
    checkEq("t1State", 32'(StateDbg), 32'(REQ));
    checkEq("t1Req", {31'b0, imem.ImemReq}, 32'd1);
    checkEq("t1Addr0", imem.ImemAddr, 32'h0);
    expQ.push_back(32'h0); expQ.push_back(32'h4); expQ.push_back(32'h8);
    tick();
    checkEq("t1Resp", 32'(StateDbg), 32'(RESP));
    checkEq("t1Bubble0", {31'b0, ValidD}, 32'd0);
    tick();
    checkEq("t1Valid0", {31'b0, ValidD}, 32'd1);
    checkEq("t1PCD0", PCD, 32'h0);
    checkEq("t1PCP4D0", PCPlus4D, 32'h4);
    checkEq("t1Addr4", imem.ImemAddr, 32'h4);
    tick();
    checkEq("t1Bubble1", {31'b0, ValidD}, 32'd0);
    tick();
    checkEq("t1Valid4", {31'b0, ValidD}, 32'd1);
    tick();
    tick();
    checkEq("t1PCD8", PCD, 32'h8);
    checkEq("t1PCP4D8", PCPlus4D, 32'hC);
    checkEq("t1AddrC", imem.ImemAddr, 32'hC);

    // 2: decode stall while the response arrives -> skid buffer
    dataXor = XOR_PAT;
    expQ.push_back(32'hC ^ XOR_PAT);
    tick();
    checkEq("t2Resp", 32'(StateDbg), 32'(RESP));
    checkEq("t2Bubble", {31'b0, ValidD}, 32'd0);
    StallD = 1'b1;
    tick();
    checkEq("t2Hold", 32'(StateDbg), 32'(HOLD));
    tick();
    tick();
    checkEq("t2StillHold", 32'(StateDbg), 32'(HOLD));
    checkEq("t2HeldValid", {31'b0, ValidD}, 32'd0);
    checkEq("t2HeldInstr", InstrD, NOP);
    StallD = 1'b0;
    tick();
    checkEq("t2Valid", {31'b0, ValidD}, 32'd1);
    checkEq("t2PCD", PCD, 32'hC);
    checkEq("t2State", 32'(StateDbg), 32'(REQ));
    checkEq("t2Addr", imem.ImemAddr, 32'h10);

    // 3: redirect while waiting for a slow response
    memLat = 2;
    expQ.push_back(32'h100 ^ XOR_PAT);
    tick();
    checkEq("t3NoDup", {31'b0, ValidD}, 32'd0);
    checkEq("t3Resp", 32'(StateDbg), 32'(RESP));
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    tick();
    PCSrcE = 1'b0;
    checkEq("t3StillResp", 32'(StateDbg), 32'(RESP));
    checkEq("t3Addr", imem.ImemAddr, 32'h100);
    checkEq("t3NoReq", {31'b0, imem.ImemReq}, 32'd0);
    tick();
    tick();
    checkEq("t3Dropped", {31'b0, ValidD}, 32'd0);
    checkEq("t3Req", 32'(StateDbg), 32'(REQ));
    checkEq("t3ReqHigh", {31'b0, imem.ImemReq}, 32'd1);
    memLat = 0;
    tick();
    tick();
    checkEq("t3Valid", {31'b0, ValidD}, 32'd1);
    checkEq("t3PCD", PCD, 32'h100);

    // 4: unaligned redirect target, then flush together with stall
    PCSrcE = 1'b1; PCTargetE = 32'h203;
    #1;
    checkEq("t4ReqSuppress", {31'b0, imem.ImemReq}, 32'd0);
    tick();
    PCSrcE = 1'b0;
    checkEq("t4Addr", imem.ImemAddr, 32'h200);
    checkEq("t4State", 32'(StateDbg), 32'(REQ));
    expQ.push_back(32'h200 ^ XOR_PAT); expQ.push_back(32'h204 ^ XOR_PAT);
    tick();
    tick();
    checkEq("t4PCD", PCD, 32'h200);
    checkEq("t4Valid", {31'b0, ValidD}, 32'd1);
    FlushD = 1'b1; StallD = 1'b1;
    tick();
    FlushD = 1'b0; StallD = 1'b0;
    checkEq("t4FlushInstr", InstrD, NOP);
    checkEq("t4FlushValid", {31'b0, ValidD}, 32'd0);
    checkEq("t4FlushPCD", PCD, 32'h0);
    checkEq("t4FlushPCP4D", PCPlus4D, 32'h0);
    tick();
    checkEq("t4PCD204", PCD, 32'h204);

    // 5: StallF, then PC wrap at the top of the address space
    StallF = 1'b1;
    #1;
    checkEq("t5StallFNoReq", {31'b0, imem.ImemReq}, 32'd0);
    tick();
    StallF = 1'b0;
    checkEq("t5StallFState", 32'(StateDbg), 32'(REQ));
    checkEq("t5StallFAddr", imem.ImemAddr, 32'h208);
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    tick();
    PCSrcE = 1'b0;
    expQ.push_back(32'hFFFF_FFFC ^ XOR_PAT);
    tick();
    tick();
    checkEq("t5PCD", PCD, 32'hFFFF_FFFC);
    checkEq("t5PCP4D", PCPlus4D, 32'h0);
    checkEq("t5WrapAddr", imem.ImemAddr, 32'h0);

    // 6: reset pulse while a response is outstanding
    StallD = 1'b1;
    PCSrcE = 1'b1; PCTargetE = 32'h300;
    tick();
    PCSrcE = 1'b0;
    memLat = 1;
    tick();
    checkEq("t6Resp", 32'(StateDbg), 32'(RESP));
    checkEq("t6HeldValid", {31'b0, ValidD}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkEq("t6RstInstr", InstrD, NOP);
    checkEq("t6RstValid", {31'b0, ValidD}, 32'd0);
    checkEq("t6RstPCD", PCD, 32'h0);
    checkEq("t6RstPCP4D", PCPlus4D, 32'h0);
    checkEq("t6RstReq", {31'b0, imem.ImemReq}, 32'd0);
    checkEq("t6RstState", 32'(StateDbg), 32'(IDLE));
    checkEq("t6RstAddr", imem.ImemAddr, 32'h0);
    StallD = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checkEq("t6StaleIgnored", {31'b0, ValidD}, 32'd0);
    checkEq("t6State", 32'(StateDbg), 32'(REQ));
    checkEq("t6Addr", imem.ImemAddr, 32'h0);
    memLat = 0;
    expQ.push_back(32'h0 ^ XOR_PAT);
    tick();
    tick();
    checkEq("t6Valid", {31'b0, ValidD}, 32'd1);
    checkEq("t6PCD", PCD, 32'h0);

    // Final report
    checkEq("sbLeftover", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
